// File: rtl/fp_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac_seq_pkg
//  Description : Shared FP16 definitions for the fp_mac sequencer and its
//                neighbours: word width, canonical zero and a NaN test that
//                works on the exponent/mantissa fields.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_mac_seq_pkg;

    localparam int          FP16_WIDTH    = 16;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    // A NaN has an all-ones exponent and a non-zero mantissa.
    function automatic logic fp16_is_nan(input logic [FP16_WIDTH-1:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

endpackage : fp_mac_seq_pkg
`default_nettype wire

// File: rtl/fp_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mac_seq
//  Description : Dot-product sequencer driving one fp_mac. Takes a command
//                (length, initial accumulator), streams FP16 (a,b) pairs into
//                the MAC one at a time with the running accumulator as the
//                addend, writes each MAC result back and returns the final sum.
//                Optional macro FP_MAC_SEQ_NAN_FLAG_EN adds a sticky res_nan
//                output flagging any NaN produced during the command.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_mac_seq
    import fp_mac_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [FP16_WIDTH-1:0] cmd_init,
    // operand stream
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FP16_WIDTH-1:0] in_a,
    input  logic [FP16_WIDTH-1:0] in_b,
    // result
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [FP16_WIDTH-1:0] res_data,
    output logic                  res_err,
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
    output logic                  res_nan,
`endif
    // fp_mac initiator interface
    output logic [FP16_WIDTH-1:0] mac_opA,
    output logic [FP16_WIDTH-1:0] mac_opB,
    output logic [FP16_WIDTH-1:0] mac_opADD,
    output logic                  mac_enA,
    output logic                  mac_enB,
    output logic                  mac_enADD,
    output logic                  mac_en_Mul_A,
    output logic                  mac_en_Mul_B,
    output logic                  mac_en_Add_A,
    output logic                  mac_en_Add_B,
    input  logic [FP16_WIDTH-1:0] mac_out_i,
    input  logic                  mac_val_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [FP16_WIDTH-1:0] r_acc;
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      r_len;
    logic                  r_err;
    logic                  r_pipe_en;

    logic w_fetch;
    logic w_in_hs;
    logic w_last;

    assign w_fetch = (r_state == S_FETCH);
    assign w_in_hs = w_fetch && in_valid;
    // r_len is never zero here: zero-length commands bypass FETCH/EXEC/WB.
    assign w_last  = (r_cnt == (r_len - 1'b1));

    // Sequencer FSM: command accept, per-pair issue/execute/writeback, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= FP16_POS_ZERO;
            r_cnt     <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_pipe_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_len   <= cmd_len;
                        r_acc   <= cmd_init;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= (cmd_len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Operands are captured by the MAC on this same edge;
                    // the pipeline enables follow for exactly one cycle.
                    if (in_valid) begin
                        r_pipe_en <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pipe_en <= 1'b0;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    // A missing MAC valid keeps the old accumulator and
                    // flags the command as broken.
                    if (mac_val_i) begin
                        r_acc <= mac_out_i;
                    end else begin
                        r_err <= 1'b1;
                    end
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= w_last ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_MAC_SEQ_NAN_FLAG_EN
    logic r_nan;

    // Sticky NaN flag: cleared on command accept, set by any NaN written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nan <= 1'b0;
        end else if (r_state == S_IDLE && cmd_valid) begin
            r_nan <= 1'b0;
        end else if (r_state == S_WB && fp16_is_nan(mac_out_i)) begin
            r_nan <= 1'b1;
        end
    end

    assign res_nan = r_nan;
`else
    // NaN tracking not built; no flag state exists.
`endif

    // Handshake outputs decoded from the state register.
    assign cmd_ready = (r_state == S_IDLE);
    assign in_ready  = w_fetch;
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_acc;
    assign res_err   = r_err;

    // Operand capture happens in the handshake cycle itself, so the MAC sees
    // the pair on the same edge the stream accepts it.
    assign mac_opA   = w_fetch ? in_a  : FP16_POS_ZERO;
    assign mac_opB   = w_fetch ? in_b  : FP16_POS_ZERO;
    assign mac_opADD = w_fetch ? r_acc : FP16_POS_ZERO;
    assign mac_enA   = w_in_hs;
    assign mac_enB   = w_in_hs;
    assign mac_enADD = w_in_hs;

    assign mac_en_Mul_A = r_pipe_en;
    assign mac_en_Mul_B = r_pipe_en;
    assign mac_en_Add_A = r_pipe_en;
    assign mac_en_Add_B = r_pipe_en;

endmodule : fp_mac_seq
`default_nettype wire

// File: tb/tb_fp_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mac_seq
//  Description : Self-checking bench for fp_mac_seq. A small behavioural
//                fp_mac stand-in returns hand-computed FP16 results for the
//                operand triples used here. Define FP_MAC_SEQ_NAN_FLAG_EN to
//                also exercise res_nan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_mac_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [15:0]      cmd_init = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic             res_err;
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
    logic             res_nan;
`endif
    logic [15:0]      mac_opA, mac_opB, mac_opADD;
    logic             mac_enA, mac_enB, mac_enADD;
    logic             mac_en_Mul_A, mac_en_Mul_B, mac_en_Add_A, mac_en_Add_B;
    logic [15:0]      mac_out_i;
    logic             mac_val_i;

    fp_mac_seq #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_init     (cmd_init),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
        .res_nan      (res_nan),
`endif
        .mac_opA      (mac_opA),
        .mac_opB      (mac_opB),
        .mac_opADD    (mac_opADD),
        .mac_enA      (mac_enA),
        .mac_enB      (mac_enB),
        .mac_enADD    (mac_enADD),
        .mac_en_Mul_A (mac_en_Mul_A),
        .mac_en_Mul_B (mac_en_Mul_B),
        .mac_en_Add_A (mac_en_Add_A),
        .mac_en_Add_B (mac_en_Add_B),
        .mac_out_i    (mac_out_i),
        .mac_val_i    (mac_val_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural fp_mac stand-in ----------------
    // Hand-computed a*b+add results for the triples the vectors use.
    function automatic logic [15:0] mac_lookup(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] c);
        case ({a, b, c})
            {16'h3C00, 16'h4000, 16'h3800}: return 16'h4100; // 1*2+0.5   = 2.5
            {16'h4200, 16'h3800, 16'h4100}: return 16'h4400; // 3*0.5+2.5 = 4.0
            {16'h3C00, 16'h3C00, 16'h0000}: return 16'h3C00; // 1*1+0     = 1.0
            {16'h4000, 16'h4000, 16'h0000}: return 16'h4400; // 2*2+0     = 4.0
            {16'h7E00, 16'h3C00, 16'h0000}: return 16'h7E00; // NaN*1+0   = NaN
            default:                        return 16'hDEAD;
        endcase
    endfunction

    logic [15:0] m_a = '0, m_b = '0, m_add = '0, m_out = '0;
    logic        m_val = 1'b0;
    int          exec_n = 0;
    int          drop_at = -1;
    logic        drop_en = 1'b0;

    always @(posedge clk) begin
        if (mac_enA)   m_a   <= mac_opA;
        if (mac_enB)   m_b   <= mac_opB;
        if (mac_enADD) m_add <= mac_opADD;
        if (mac_en_Add_B) begin
            m_out  <= mac_lookup(m_a, m_b, m_add);
            m_val  <= !(drop_en && exec_n == drop_at);
            exec_n <= exec_n + 1;
        end else begin
            m_val  <= 1'b0;
        end
    end
    assign mac_out_i = m_out;
    assign mac_val_i = m_val;

    // Enable activity monitors.
    int en_cnt = 0, en_bad = 0, pipe_cnt = 0;
    always @(posedge clk) begin
        if (mac_enA && mac_enB && mac_enADD) en_cnt <= en_cnt + 1;
        if ((mac_enA || mac_enB || mac_enADD) && !(in_valid && in_ready)) en_bad <= en_bad + 1;
        if (mac_en_Mul_A && mac_en_Mul_B && mac_en_Add_A && mac_en_Add_B) pipe_cnt <= pipe_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string            name;
        logic [LEN_W-1:0] len;
        logic [15:0]      init;
        logic [15:0]      a0, b0, a1, b1;
        int               gap;      // idle cycles before each pair
        int               hold;     // cycles res_ready stays low in DONE
        logic             drop;     // suppress MAC valid on the first pair
        logic [15:0]      exp_data;
        logic             exp_err;
        logic             exp_nan;
        int               exp_lat;  // 0 = not checked
    } vec_t;

    vec_t vecs[$];

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        chk({tag, " in_ready"},  in_ready, 0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_err"},   res_err, 0);
        chk({tag, " res_data"},  res_data, 16'h0000);
        chk({tag, " mac_ops"},   {mac_opA, mac_opB}, 32'h0);
        chk({tag, " mac_opADD"}, mac_opADD, 16'h0000);
        chk({tag, " enables"},   {mac_enA, mac_enB, mac_enADD, mac_en_Mul_A,
                                  mac_en_Mul_B, mac_en_Add_A, mac_en_Add_B}, 0);
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
        chk({tag, " res_nan"},   res_nan, 0);
`endif
    endtask

    // Drive one pair and wait (bounded) for its handshake.
    task automatic feed_pair(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " in handshake"}, ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic accept_cmd(input logic [LEN_W-1:0] len, input logic [15:0] init, output int c0);
        @(negedge clk);
        chk("cmd_ready before cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_init  = init;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int   c0, e0, p0, b0, lat;
        logic got;
        e0 = en_cnt;
        p0 = pipe_cnt;
        b0 = en_bad;
        if (v.drop) begin
            drop_at = exec_n;
            drop_en = 1'b1;
        end
        accept_cmd(v.len, v.init, c0);
        for (int i = 0; i < int'(v.len); i++) begin
            for (int g = 0; g < v.gap; g++) begin
                @(posedge clk);
                #1;
            end
            feed_pair(v.name, (i == 0) ? v.a0 : v.a1, (i == 0) ? v.b0 : v.b1);
        end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        lat = cyc - c0 + 1;
        chk({v.name, " res_valid seen"}, got, 1);
        if (v.exp_lat != 0) chk({v.name, " latency"}, lat, v.exp_lat);
        chk({v.name, " res_data"}, res_data, v.exp_data);
        chk({v.name, " res_err"}, res_err, v.exp_err);
        chk({v.name, " operand enables"}, en_cnt - e0, int'(v.len));
        chk({v.name, " pipeline enables"}, pipe_cnt - p0, int'(v.len));
        chk({v.name, " stray enables"}, en_bad - b0, 0);
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
        chk({v.name, " res_nan"}, res_nan, v.exp_nan);
`endif
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({v.name, " hold res_valid"}, res_valid, 1);
            chk({v.name, " hold res_data"}, res_data, v.exp_data);
            chk({v.name, " hold cmd_ready"}, cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        drop_en = 1'b0;
        @(negedge clk);
        chk({v.name, " back to idle"}, {cmd_ready, res_valid}, 2'b10);
    endtask

    initial begin : main
        int c0;
        vecs.push_back('{"sum",     8'd2, 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 16'h3800,
                         0, 0, 1'b0, 16'h4400, 1'b0, 1'b0, 7});
        vecs.push_back('{"zerolen", 8'd0, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                         0, 0, 1'b0, 16'h3C00, 1'b0, 1'b0, 1});
        vecs.push_back('{"gapped",  8'd2, 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 16'h3800,
                         4, 0, 1'b0, 16'h4400, 1'b0, 1'b0, 0});
        vecs.push_back('{"reshold", 8'd2, 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 16'h3800,
                         0, 5, 1'b0, 16'h4400, 1'b0, 1'b0, 7});
        vecs.push_back('{"noval",   8'd2, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                         0, 0, 1'b1, 16'h3C00, 1'b1, 1'b0, 7});
        vecs.push_back('{"len1",    8'd1, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000,
                         0, 0, 1'b0, 16'h4400, 1'b0, 1'b0, 4});
`ifdef FP_MAC_SEQ_NAN_FLAG_EN
        vecs.push_back('{"nan",     8'd1, 16'h0000, 16'h7E00, 16'h3C00, 16'h0000, 16'h0000,
                         0, 0, 1'b0, 16'h7E00, 1'b0, 1'b1, 4});
        vecs.push_back('{"clean",   8'd1, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000,
                         0, 0, 1'b0, 16'h4400, 1'b0, 1'b0, 4});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table of directed commands.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the EXEC cycle of the second pair, then a fresh command.
        accept_cmd(8'd2, 16'h0000, c0);
        feed_pair("midrst p1", 16'h3C00, 16'h3C00);
        feed_pair("midrst p2", 16'h3C00, 16'h3C00);
        @(negedge clk);
        chk("midrst in EXEC", mac_en_Mul_A, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        run_vec(vecs[5]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fp_mac_seq
`default_nettype wire
